cache_ctrl_wb: RTL



---
 rtl/cache_ctrl_wb.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb
//   Write-back, direct-mapped cache controller FSM between a CPU memory port,
//   a cache data/tag array and a fixed-latency main memory. The line size
//   and the memory latency are parameters. The CPU request is latched when it
//   is accepted. Rd and Wr asserted together go to an error state. Hit, miss
//   and write-back events are counted in saturating counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   Rd, Wr, addr, data_input CPU request (sampled only in IDLE)
//   done, ch, stall, errCtrl CPU status: op complete, cache hit, stall, error
//   enable, comp, write_c,   cache array controls and request fields
//   valid_in, tag_in, index,
//   offset, data_in
//   hit, valid, dirty,       cache array response
//   tag_out, data_out
//   wr_m, rd_m, addr_m,      main memory request
//   data_in_m
//   data_out_m               main memory read data, MEM_LAT cycles after rd_m
//   hit_cnt, miss_cnt,       saturating event counters
//   wb_cnt
module cache_ctrl_wb #(
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = TAG_W + INDEX_W + OFFSET_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Rd,
    input  logic                Wr,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_input,
    output logic                done,
    output logic                ch,
    output logic                stall,
    output logic                errCtrl,
    output logic                enable,
    output logic                comp,
    output logic                write_c,
    output logic                valid_in,
    output logic [TAG_W-1:0]    tag_in,
    output logic [INDEX_W-1:0]  index,
    output logic [OFFSET_W-1:0] offset,
    output logic [DATA_W-1:0]   data_in,
    input  logic                hit,
    input  logic                valid,
    input  logic                dirty,
    input  logic [TAG_W-1:0]    tag_out,
    input  logic [DATA_W-1:0]   data_out,
    output logic                wr_m,
    output logic                rd_m,
    output logic [ADDR_W-1:0]   addr_m,
    output logic [DATA_W-1:0]   data_in_m,
    input  logic [DATA_W-1:0]   data_out_m,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic [CNT_W-1:0]    wb_cnt
);

    // Word-within-line index width and the length of the refill phase.
    localparam int WI_W     = OFFSET_W - 1;
    localparam int WORDS    = 1 << WI_W;
    localparam int FILL_LEN = WORDS + MEM_LAT;
    localparam int CW       = $clog2(FILL_LEN) + 1;

    localparam logic [CW-1:0] WB_LAST   = CW'(WORDS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(FILL_LEN - 1);
    localparam logic [CW-1:0] WORDS_C   = CW'(WORDS);
    localparam logic [CW-1:0] LAT_C     = CW'(MEM_LAT);

    typedef enum logic [2:0] {
        IDLE, ERR, COMP, WB, WB_GAP, FILL, MERGE, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                iswr_q, iswr_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]    wb_cnt_q, wb_cnt_d;

    logic [TAG_W-1:0]    tag_lat;
    logic [INDEX_W-1:0]  idx_lat;
    logic [OFFSET_W-1:0] off_lat;

    assign tag_lat = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_lat = addr_q[OFFSET_W+INDEX_W-1 -: INDEX_W];
    assign off_lat = addr_q[OFFSET_W-1:0];

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;

    // Counter increment that holds at the all-ones value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            iswr_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            iswr_q     <= iswr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        iswr_d     = iswr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;

        done      = 1'b0;
        ch        = 1'b0;
        stall     = 1'b1;
        errCtrl   = 1'b0;
        enable    = 1'b0;
        comp      = 1'b0;
        write_c   = 1'b0;
        valid_in  = 1'b0;
        tag_in    = tag_lat;
        index     = idx_lat;
        offset    = off_lat;
        data_in   = data_q;
        wr_m      = 1'b0;
        rd_m      = 1'b0;
        addr_m    = '0;
        data_in_m = data_out;

        case (state_q)
            IDLE: begin
                stall  = 1'b0;
                tag_in = addr[ADDR_W-1 -: TAG_W];
                index  = addr[OFFSET_W+INDEX_W-1 -: INDEX_W];
                offset = addr[OFFSET_W-1:0];
                cnt_d  = '0;
                if (Rd ^ Wr) begin
                    addr_d  = addr;
                    data_d  = data_input;
                    iswr_d  = Wr;
                    state_d = COMP;
                end else if (Rd && Wr) begin
                    state_d = ERR;
                end
            end

            COMP: begin
                enable  = 1'b1;
                comp    = 1'b1;
                write_c = iswr_q;
                cnt_d   = '0;
                if (hit && valid) begin
                    done      = 1'b1;
                    ch        = 1'b1;
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    state_d   = IDLE;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (valid && dirty) begin
                        wb_cnt_d = sat_inc(wb_cnt_q);
                        state_d  = WB;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            // Victim line is streamed out one word per cycle, addressed by the
            // victim's own tag rather than the request tag.
            WB: begin
                enable = 1'b1;
                offset = {cnt_q[WI_W-1:0], 1'b0};
                wr_m   = 1'b1;
                addr_m = {tag_out, idx_lat, cnt_q[WI_W-1:0], 1'b0};
                if (cnt_q == WB_LAST) begin
                    cnt_d   = '0;
                    state_d = WB_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Let the memory drain the last write before reads are issued.
            WB_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Reads go out on k < WORDS; the word read at cycle k returns at
            // k + MEM_LAT, so the cache write side trails by MEM_LAT cycles.
            FILL: begin
                if (cnt_q < WORDS_C) begin
                    rd_m   = 1'b1;
                    addr_m = {tag_lat, idx_lat, cnt_q[WI_W-1:0], 1'b0};
                end
                if (cnt_q >= LAT_C) begin
                    enable   = 1'b1;
                    write_c  = 1'b1;
                    valid_in = 1'b1;
                    offset   = {WI_W'(cnt_q - LAT_C), 1'b0};
                    data_in  = data_out_m;
                end
                if (cnt_q == FILL_LAST) begin
                    cnt_d   = '0;
                    state_d = iswr_q ? MERGE : DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Compare-write of the CPU word into the fresh line marks it dirty.
            MERGE: begin
                enable   = 1'b1;
                comp     = 1'b1;
                write_c  = 1'b1;
                valid_in = 1'b1;
                state_d  = DONE;
            end

            DONE: begin
                enable  = 1'b1;
                comp    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end

            // ERR and any unreachable encoding.
            default: begin
                errCtrl = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule
